// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e          - receiver/transmitter FSM state encoding
//   DATA_BITS             - payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT  - 50 MHz / 115200 baud, rounded
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous rx pin plus one
// delay flop for falling-edge detection. All flops reset to 1 (idle line).
//   clk   - system clock
//   reset - asynchronous active-low reset
//   rx    - raw serial pin
//   rx_s  - synchronised rx
//   fall  - one-cycle high when rx_s goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_sq;
  logic rx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sq   <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sq   <= rx_meta;
      rx_d    <= rx_sq;
    end
  end

  assign rx_s = rx_sq;
  // A line held low produces no further edges until it has gone high again.
  assign fall = rx_d & ~rx_sq;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first. Detects a start bit, confirms it at
// mid-bit, samples each data bit one bit period later and checks the stop bit.
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   rx        - serial line, idle high, asynchronous to clk
//   data_out  - last correctly framed byte, held until the next good frame
//   rx_done   - one-cycle strobe, data_out valid in the same cycle
//   frame_err - one-cycle strobe when the stop bit samples 0
//   busy      - high while in START, DATA or STOP
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             HALF_BIT = CLKS_PER_BIT / 2;
  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  uart_state_e          state_q, state_n;
  logic [CW-1:0]        cnt_q,   cnt_n;
  logic [2:0]           idx_q,   idx_n;
  logic [DATA_BITS-1:0] sh_q,    sh_n;
  logic [DATA_BITS-1:0] data_q,  data_n;
  logic                 done_q,  done_n;
  logic                 ferr_q,  ferr_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      data_q  <= data_n;
      done_q  <= done_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CW'(1);
    idx_n   = idx_q;
    sh_n    = sh_q;
    data_n  = data_q;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_n = '0;
          idx_n = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh_q[DATA_BITS-1:1]};
          idx_n = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so an immediately following start bit is seen.
        if (cnt_q == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_n = sh_q;
            done_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with CLKS_PER_BIT=16 and a 10 ns
// clock (160 ns per bit). Stimulus pushes the expected strobe into a queue;
// the monitor pops and compares whenever rx_done or frame_err is seen.
module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int BIT_NS = CPB * 10;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  exp_t       q[$];
  int         checks;
  int         failures;
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_done(input logic [7:0] b);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = b;
    last_good = b;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (rx_done || frame_err)) begin
        chk("strobe_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe rx_done=%0b frame_err=%0b data_out=%0h expected=none at %0t",
                   rx_done, frame_err, data_out, $time);
        end else begin
          e = q.pop_front();
          chk("strobe_rx_done", {31'd0, rx_done}, {31'd0, ~e.is_err});
          chk("strobe_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("strobe_data_out", {24'd0, data_out}, {24'd0, e.data});
          chk("strobe_busy_low", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    last_good = 8'h00;
    rx        = 1'b1;
    reset     = 1'b0;
    idle(3);
    chk("reset_data_out", {24'd0, data_out}, 32'h00);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(5);

    // Single byte at exact baud.
    push_done(8'hA5);
    send(8'hA5, 1'b1, BIT_NS);
    idle(20);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_data_held", {24'd0, data_out}, 32'hA5);

    // Back-to-back frames, start bit right after each stop bit.
    push_done(8'h00);
    push_done(8'hFF);
    push_done(8'h3C);
    send(8'h00, 1'b1, BIT_NS);
    send(8'hFF, 1'b1, BIT_NS);
    send(8'h3C, 1'b1, BIT_NS);
    idle(20);

    // Bad stop bit: frame_err, data_out keeps 3C.
    push_err();
    send(8'h55, 1'b0, BIT_NS);
    idle(20);
    chk("ferr_data_held", {24'd0, data_out}, 32'h3C);

    // Four-cycle glitch is rejected at the start-bit check.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(20);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    push_done(8'h81);
    send(8'h81, 1'b1, BIT_NS);
    idle(20);

    // Reset in the middle of the data bits of C3.
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = 8'hC3 >> i;
      #(BIT_NS);
    end
    #(BIT_NS / 2);
    chk("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    last_good = 8'h00;
    chk("abort_data_out", {24'd0, data_out}, 32'h00);
    chk("abort_rx_done", {31'd0, rx_done}, 32'd0);
    chk("abort_frame_err", {31'd0, frame_err}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(5);
    push_done(8'h7E);
    send(8'h7E, 1'b1, BIT_NS);
    idle(20);

    // Baud mismatch: +4% and -4% bit period.
    push_done(8'h96);
    send(8'h96, 1'b1, 166);
    idle(20);
    push_done(8'h96);
    send(8'h96, 1'b1, 154);
    idle(20);

    // Break: line low for three frame times gives exactly one frame_err.
    push_err();
    rx = 1'b0;
    #(3 * 10 * BIT_NS);
    rx = 1'b1;
    idle(40);
    chk("break_data_held", {24'd0, data_out}, 32'h96);

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
